// File: rtl/fp_convert_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_convert_seq_if
//  Description : Handshake bundle for fp_convert_seq. It carries the sample
//                side (in_valid/in_ready, D, rnd_mode) and the result side
//                (out_valid/out_ready, S, E, F, ovf).
//                slave  : converter view (accepts samples, produces results)
//                master : environment view (supplies samples, takes results)
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_convert_seq_if #(
    parameter int SIG_W = 4,
    parameter int EXP_W = 3,
    parameter int IN_W  = 12
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  D;
    logic             rnd_mode;
    logic             out_valid;
    logic             out_ready;
    logic             S;
    logic [EXP_W-1:0] E;
    logic [SIG_W-1:0] F;
    logic             ovf;

    modport slave (
        input  in_valid, D, rnd_mode, out_ready,
        output in_ready, out_valid, S, E, F, ovf
    );

    modport master (
        output in_valid, D, rnd_mode, out_ready,
        input  in_ready, out_valid, S, E, F, ovf
    );
endinterface
`default_nettype wire

// File: rtl/fp_convert_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_convert_seq
//  Description : Serial converter from a two's-complement linear sample to
//                sign / exponent / significand floating point, value = F*2^E.
//                The magnitude is normalised one bit per clock (at most
//                MAX_EXP shifts), then truncated or rounded half-up.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - fp_convert_seq_if.slave:
//                       in_valid/in_ready, D, rnd_mode (sampled at accept),
//                       out_valid/out_ready, S, E, F, ovf
//  Revision    : 1.0  initial release
// ============================================================================
module fp_convert_seq #(
    parameter int SIG_W = 4,
    parameter int EXP_W = 3,
    parameter int IN_W  = 12
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fp_convert_seq_if.slave    bus
);

    // The exponent range must exactly cover the leading-zero span of the
    // magnitude, otherwise the field extraction below is meaningless.
    generate
        if (IN_W != SIG_W + (2 ** EXP_W)) begin : g_param_check
            $error("fp_convert_seq: IN_W must equal SIG_W + 2**EXP_W");
        end
    endgenerate

    localparam int               c_mag_w   = IN_W - 1;
    localparam int               c_rb_idx  = IN_W - 2 - SIG_W;
    localparam logic [EXP_W-1:0] c_max_exp = '1;
    localparam logic [EXP_W-1:0] c_exp_one = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [SIG_W:0]   c_sig_one = {{SIG_W{1'b0}}, 1'b1};
    localparam logic [c_mag_w-1:0] c_mag_one = {{(c_mag_w-1){1'b0}}, 1'b1};
    localparam logic [IN_W-1:0]  c_in_min  = {1'b1, {(IN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [c_mag_w-1:0] r_mag;
    logic [c_mag_w-1:0] w_mag_nxt;
    logic [EXP_W-1:0]   r_exp;
    logic [EXP_W-1:0]   w_exp_nxt;
    logic               r_sign;
    logic               w_sign_nxt;
    logic               r_mode;
    logic               w_mode_nxt;
    logic               r_clamp;
    logic               w_clamp_nxt;

    logic               r_s;
    logic               w_s_nxt;
    logic [EXP_W-1:0]   r_e;
    logic [EXP_W-1:0]   w_e_nxt;
    logic [SIG_W-1:0]   r_f;
    logic [SIG_W-1:0]   w_f_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;

    // ---------------------------------------------------------------------
    // Accept-side magnitude. Only the low IN_W-1 bits of -D are needed since
    // |D| < 2^(IN_W-1) for every D except the most negative one, which wraps
    // to zero here and is clamped to all ones instead.
    // ---------------------------------------------------------------------
    logic               w_in_neg;
    logic               w_in_min;
    logic [c_mag_w-1:0] w_in_mag;

    assign w_in_neg = bus.D[IN_W-1];
    assign w_in_min = (bus.D == c_in_min);

    always_comb begin
        w_in_mag = bus.D[c_mag_w-1:0];
        if (w_in_min) begin
            w_in_mag = '1;
        end else if (w_in_neg) begin
            w_in_mag = ~bus.D[c_mag_w-1:0] + c_mag_one;
        end
    end

    // ---------------------------------------------------------------------
    // Normalisation / rounding datapath
    // ---------------------------------------------------------------------
    logic               w_finish;
    logic [SIG_W-1:0]   w_fr;
    logic               w_rb;
    logic               w_round;
    logic [SIG_W:0]     w_sum;
    logic               w_sat;

    assign w_finish = (r_exp == '0) || r_mag[c_mag_w-1];
    assign w_fr     = r_mag[c_mag_w-1 -: SIG_W];
    assign w_rb     = r_mag[c_rb_idx];
    assign w_round  = r_mode && w_rb;
    assign w_sum    = {1'b0, w_fr} + c_sig_one;
    // A round carry at the top exponent has nowhere to go: hold all ones.
    assign w_sat    = w_round && (r_exp == c_max_exp) && (&w_fr);

    // ---------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_exp_nxt   = r_exp;
        w_sign_nxt  = r_sign;
        w_mode_nxt  = r_mode;
        w_clamp_nxt = r_clamp;
        w_s_nxt     = r_s;
        w_e_nxt     = r_e;
        w_f_nxt     = r_f;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_sign_nxt  = w_in_neg;
                    w_mode_nxt  = bus.rnd_mode;
                    w_mag_nxt   = w_in_mag;
                    w_clamp_nxt = w_in_min;
                    w_exp_nxt   = c_max_exp;
                    w_state_nxt = ST_NORM;
                end
            end

            ST_NORM: begin
                if (w_finish) begin
                    w_s_nxt   = r_sign;
                    w_ovf_nxt = r_clamp;
                    if (w_sat) begin
                        w_f_nxt   = '1;
                        w_e_nxt   = c_max_exp;
                        w_ovf_nxt = 1'b1;
                    end else if (w_round && w_sum[SIG_W]) begin
                        // Carry out renormalises to 100..0 one octave up.
                        w_f_nxt = w_sum[SIG_W:1];
                        w_e_nxt = r_exp + c_exp_one;
                    end else if (w_round) begin
                        w_f_nxt = w_sum[SIG_W-1:0];
                        w_e_nxt = r_exp;
                    end else begin
                        w_f_nxt = w_fr;
                        w_e_nxt = r_exp;
                    end
                    w_state_nxt = ST_DONE;
                end else begin
                    w_mag_nxt = {r_mag[c_mag_w-2:0], 1'b0};
                    w_exp_nxt = r_exp - c_exp_one;
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mag   <= '0;
            r_exp   <= '0;
            r_sign  <= 1'b0;
            r_mode  <= 1'b0;
            r_clamp <= 1'b0;
            r_s     <= 1'b0;
            r_e     <= '0;
            r_f     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mag   <= w_mag_nxt;
            r_exp   <= w_exp_nxt;
            r_sign  <= w_sign_nxt;
            r_mode  <= w_mode_nxt;
            r_clamp <= w_clamp_nxt;
            r_s     <= w_s_nxt;
            r_e     <= w_e_nxt;
            r_f     <= w_f_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.S         = r_s;
    assign bus.E         = r_e;
    assign bus.F         = r_f;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
